// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with trap/redirect/branch/call/return and a circular return-address stack
module pc_gen #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
   parameter int              STEP      = 4,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            trap,
   input  logic            redirect_en,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            branch_en,
   input  logic            call_en,
   input  logic [XLEN-1:0] branch_off,
   input  logic            ret_en,
   output logic [XLEN-1:0] pc_out,
   output logic            pc_valid,
   output logic            ras_empty,
   output logic            ras_full
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   logic [XLEN-1:0] ras [RAS_DEPTH];
   logic [PW-1:0]   ptr, top_idx;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] seq_pc, rel_pc, nxt_pc;
   logic            active, push, pop;
   assign ras_empty = cnt == '0;
   assign ras_full  = cnt == CW'(RAS_DEPTH);
   // ptr is the next free slot; when full it points at the oldest entry, so a push overwrites it
   always_comb begin
      seq_pc  = pc_out + XLEN'(STEP);
      rel_pc  = pc_out + branch_off;
      top_idx = ptr - PW'(1);
      active  = !trap && !redirect_en && !stall;
      pop     = active && ret_en && !ras_empty;
      push    = active && !ret_en && call_en;
      nxt_pc  = trap ? TRAP_VEC :
                redirect_en ? redirect_pc :
                stall ? pc_out :
                ret_en ? (ras_empty ? seq_pc : ras[top_idx]) :
                (call_en || branch_en) ? rel_pc : seq_pc;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_out   <= RESET_VEC;
         pc_valid <= 1'b0;
         ptr      <= '0;
         cnt      <= '0;
      end else begin
         pc_out   <= nxt_pc;
         pc_valid <= 1'b1;
         if (push) begin
            ptr <= ptr + PW'(1);
            cnt <= ras_full ? cnt : cnt + CW'(1);
         end else if (pop) begin
            ptr <= top_idx;
            cnt <= cnt - CW'(1);
         end
      end
   end
   always_ff @(posedge clk)
      if (push) ras[ptr] <= seq_pc;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table plus reset-in-flight sequence for pc_gen
module tb_pc_gen;
   logic        clk = 1'b0, reset = 1'b1;
   logic        stall = 0, trap = 0, redirect_en = 0, branch_en = 0, call_en = 0, ret_en = 0;
   logic [31:0] redirect_pc = 0, branch_off = 0;
   logic [31:0] pc_out;
   logic        pc_valid, ras_empty, ras_full;
   int          pass = 0, total = 0;

   pc_gen dut (.clk(clk), .reset(reset), .stall(stall), .trap(trap), .redirect_en(redirect_en),
               .redirect_pc(redirect_pc), .branch_en(branch_en), .call_en(call_en),
               .branch_off(branch_off), .ret_en(ret_en), .pc_out(pc_out), .pc_valid(pc_valid),
               .ras_empty(ras_empty), .ras_full(ras_full));

   always #5 clk = ~clk;

   typedef struct {
      logic        st, tr, rd, br, ca, rt;
      logic [31:0] rpc, off, epc;
      logic        emp, ful;
   } vec_t;
   vec_t v[$];

   function automatic vec_t mk(logic st, logic tr, logic rd, logic [31:0] rpc, logic br, logic ca,
                               logic rt, logic [31:0] off, logic [31:0] epc, logic emp, logic ful);
      vec_t x;
      x.st = st; x.tr = tr; x.rd = rd; x.rpc = rpc; x.br = br; x.ca = ca; x.rt = rt;
      x.off = off; x.epc = epc; x.emp = emp; x.ful = ful;
      return x;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(vec_t x);
      stall = x.st; trap = x.tr; redirect_en = x.rd; redirect_pc = x.rpc;
      branch_en = x.br; call_en = x.ca; ret_en = x.rt; branch_off = x.off;
   endtask

   initial begin
      //          st tr rd rpc           br ca rt off           exp pc        emp ful
      v.push_back(mk(0, 0, 0, 0,            0, 0, 0, 0,            32'h4,        1, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 0, 0, 0,            32'h8,        1, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 0, 0, 0,            32'hC,        1, 0));
      v.push_back(mk(0, 0, 1, 32'h40,       0, 0, 0, 0,            32'h40,       1, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 1, 0, 32'h100,      32'h140,      0, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 0, 1, 0,            32'h44,       1, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 0, 1, 0,            32'h48,       1, 0));
      v.push_back(mk(1, 0, 0, 0,            1, 0, 0, 32'h10,       32'h48,       1, 0));
      v.push_back(mk(1, 0, 1, 32'h2000,     0, 0, 0, 0,            32'h2000,     1, 0));
      v.push_back(mk(0, 1, 1, 32'h3000,     0, 0, 0, 0,            32'h100,      1, 0));
      v.push_back(mk(0, 0, 0, 0,            1, 0, 0, 32'h20,       32'h120,      1, 0));
      v.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 0, 0, 0, 0,            32'hFFFFFFFC, 1, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 0, 0, 0,            32'h0,        1, 0));
      v.push_back(mk(0, 0, 1, 32'h10,       0, 0, 0, 0,            32'h10,       1, 0));
      v.push_back(mk(0, 0, 0, 0,            1, 0, 0, 32'hFFFFFFF0, 32'h0,        1, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 1, 0, 32'h100,      32'h100,      0, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 1, 0, 32'h100,      32'h200,      0, 0));
      v.push_back(mk(1, 0, 0, 0,            0, 1, 1, 32'h100,      32'h200,      0, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 1, 0, 32'h100,      32'h300,      0, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 1, 0, 32'h100,      32'h400,      0, 1));
      v.push_back(mk(0, 0, 0, 0,            0, 1, 0, 32'h100,      32'h500,      0, 1));
      v.push_back(mk(0, 0, 0, 0,            0, 0, 1, 0,            32'h404,      0, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 0, 1, 0,            32'h304,      0, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 0, 1, 0,            32'h204,      0, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 0, 1, 0,            32'h104,      1, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 0, 1, 0,            32'h108,      1, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 1, 0, 32'h8,        32'h110,      0, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 1, 1, 32'h8,        32'h10C,      1, 0));
      v.push_back(mk(0, 0, 0, 0,            0, 1, 0, 32'h40,       32'h14C,      0, 0));

      #1;
      chk("reset pc", pc_out, 32'h0);
      chk("reset valid", 32'(pc_valid), 0);
      chk("reset empty", 32'(ras_empty), 1);
      chk("reset full", 32'(ras_full), 0);
      call_en = 1; branch_off = 32'h100;
      #6;
      chk("reset hold pc", pc_out, 32'h0);
      chk("reset hold valid", 32'(pc_valid), 0);
      call_en = 0; branch_off = 0;
      reset = 0;

      for (int i = 0; i < v.size(); i++) begin
         drive(v[i]);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d pc", i), pc_out, v[i].epc);
         chk($sformatf("v%0d valid", i), 32'(pc_valid), 1);
         chk($sformatf("v%0d empty", i), 32'(ras_empty), 32'(v[i].emp));
         chk($sformatf("v%0d full", i), 32'(ras_full), 32'(v[i].ful));
      end

      // reset lands between edges while a call is still held on the inputs
      #3 reset = 1;
      #1;
      chk("mid reset pc", pc_out, 32'h0);
      chk("mid reset empty", 32'(ras_empty), 1);
      chk("mid reset valid", 32'(pc_valid), 0);
      @(posedge clk);
      #1;
      chk("mid reset hold pc", pc_out, 32'h0);
      chk("mid reset hold empty", 32'(ras_empty), 1);
      #2 reset = 0;
      call_en = 0; ret_en = 1;
      @(posedge clk);
      #1;
      chk("post reset ret pc", pc_out, 32'h4);
      chk("post reset valid", 32'(pc_valid), 1);
      chk("post reset empty", 32'(ras_empty), 1);
      ret_en = 0;

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and offset width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, PC value loaded on trap.
REQ-004 SHALL have parameter STEP, default 4, sequential increment in bytes.
REQ-005 SHALL have parameter RAS_DEPTH, default 4 (power of two, >=2), return-address-stack entries.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port stall, input, 1, freeze PC and RAS.
REQ-009 SHALL have port trap, input, 1, load TRAP_VEC.
REQ-010 SHALL have port redirect_en, input, 1, absolute redirect (mispredict/flush).
REQ-011 SHALL have port redirect_pc, input, XLEN, absolute redirect target.
REQ-012 SHALL have port branch_en, input, 1, PC-relative jump.
REQ-013 SHALL have port call_en, input, 1, PC-relative jump plus RAS push.
REQ-014 SHALL have port branch_off, input, XLEN, two's-complement offset for branch/call.
REQ-015 SHALL have port ret_en, input, 1, jump to RAS top plus pop.
REQ-016 SHALL have port pc_out, output, XLEN, current PC (registered).
REQ-017 SHALL have port pc_valid, output, 1, pc_out holds a fetchable address.
REQ-018 SHALL have port ras_empty, output, 1, RAS count == 0.
REQ-019 SHALL have port ras_full, output, 1, RAS count == RAS_DEPTH.

Function
REQ-020 SHALL update pc_out and RAS only on rising clk; all outputs registered or derived from registered state.
REQ-021 SHALL apply per-cycle priority: trap > redirect_en > stall > ret_en > call_en > branch_en > sequential.
REQ-022 SHALL on trap: pc_out <= TRAP_VEC; RAS unchanged; overrides stall.
REQ-023 SHALL on redirect_en (no trap): pc_out <= redirect_pc; RAS unchanged; overrides stall.
REQ-024 SHALL on stall (no trap/redirect): hold pc_out and RAS; ignore ret/call/branch that cycle.
REQ-025 SHALL on ret_en with RAS non-empty: pc_out <= top entry, count-1, pointer decrements.
REQ-026 SHALL on ret_en with RAS empty: pc_out <= pc_out+STEP, RAS unchanged (no underflow wrap).
REQ-027 SHALL on call_en: push pc_out+STEP, pc_out <= pc_out+branch_off.
REQ-028 SHALL on call_en with RAS full: overwrite oldest entry (circular pointer), count saturates at RAS_DEPTH.
REQ-029 SHALL on branch_en: pc_out <= pc_out+branch_off; RAS unchanged.
REQ-030 SHALL otherwise: pc_out <= pc_out+STEP.
REQ-031 SHALL compute all additions modulo 2^XLEN (wrap, no overflow flag).
REQ-032 SHALL pass target values unaltered (no alignment masking).
REQ-033 SHALL perform at most one RAS operation per cycle, as selected by REQ-021.

Reset
REQ-034 SHALL on reset asserted, immediately: pc_out=RESET_VEC, pc_valid=0, RAS count=0, pointer=0, ras_empty=1, ras_full=0.
REQ-035 SHALL hold reset values while reset high regardless of other inputs.
REQ-036 SHALL on first rising clk after reset deassert: pc_valid<=1 and pc_out updates per REQ-021; pc_valid stays 1 until next reset.
REQ-037 SHALL discard RAS contents on reset asserted mid-operation; entry data need not be cleared.

Verification
REQ-038 SHALL cover: reset release, 3 idle clocks -> pc_out 0x0,0x4,0x8,0xC; pc_valid 1 from first edge.
REQ-039 SHALL cover: PC=0x40, call_en off=0x100 -> PC=0x140, RAS top 0x44; next ret_en -> PC=0x44, ras_empty=1.
REQ-040 SHALL cover: 5 calls with RAS_DEPTH=4 -> ras_full=1; 4 rets return last 4 return addresses LIFO; 5th ret -> sequential PC+4.
REQ-041 SHALL cover: stall+branch_en -> PC held; stall+redirect_en 0x2000 -> PC=0x2000; trap+redirect_en -> PC=0x100.
REQ-042 SHALL cover: PC=0xFFFF_FFFC sequential -> 0x0; branch_off=0xFFFF_FFF0 from 0x10 -> 0x0.
REQ-043 SHALL cover: reset asserted between clk edges mid-call-sequence -> pc_out=RESET_VEC immediately, ras_empty=1.
